// File: rtl/ascon_auth_release.sv
// Receiver-side release gate for the Ascon decryption core: launches one decryption,
// checks the computed tag in constant time and releases plaintext only on a match.
module ascon_auth_release #(
    parameter int text_l  = 40,
    parameter int CHUNK   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [127:0]      tag_in,
    output logic              dec_start,
    input  logic              dec_ready,
    input  logic [127:0]      dec_tag,
    input  logic [text_l-1:0] dec_pt,
    output logic [text_l-1:0] pt_out,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic              auth_fail,
    output logic              timeout,
    output logic              busy,
    output logic              done
);

    localparam int NCHUNK = 128 / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_CMP, S_RELEASE, S_REJECT
    } state_t;

    state_t              state_q, state_d;
    logic [127:0]        tag_q, tag_d;
    logic [127:0]        cap_tag_q, cap_tag_d;
    logic [text_l-1:0]   cap_pt_q, cap_pt_d;
    logic                diff_q, diff_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dec_ready_q, dec_ready_d;
    logic                dec_start_q, dec_start_d;
    logic [text_l-1:0]   pt_out_q, pt_out_d;
    logic                pt_valid_q, pt_valid_d;
    logic                auth_fail_q, auth_fail_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [127:0]        tag_xor_sh;
    logic [CNT_W-1:0]    cnt_inc;
    logic                ready_rise;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        tag_d       = tag_q;
        cap_tag_d   = cap_tag_q;
        cap_pt_d    = cap_pt_q;
        diff_d      = diff_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dec_ready_d = dec_ready;
        dec_start_d = 1'b0;
        pt_out_d    = pt_out_q;
        pt_valid_d  = pt_valid_q;
        auth_fail_d = auth_fail_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;

        tag_xor_sh = (tag_q ^ cap_tag_q) >> (int'(idx_q) * CHUNK);
        cnt_inc    = cnt_q + CNT_W'(1);
        ready_rise = dec_ready && !dec_ready_q;

        unique case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse belongs to the finished transaction.
                if (start && !done_q) begin
                    tag_d       = tag_in;
                    auth_fail_d = 1'b0;
                    timeout_d   = 1'b0;
                    diff_d      = 1'b0;
                    dec_start_d = 1'b1;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ready_rise) begin
                    cap_tag_d = dec_tag;
                    cap_pt_d  = dec_pt;
                    idx_d     = '0;
                    state_d   = S_CMP;
                end else if (cnt_inc == LAST_CNT) begin
                    auth_fail_d = 1'b1;
                    timeout_d   = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_REJECT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_CMP: begin
                // All chunks are always visited so the verdict time is independent of the data.
                diff_d = diff_q | (|tag_xor_sh[CHUNK-1:0]);
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    if (!diff_d) begin
                        pt_valid_d = 1'b1;
                        pt_out_d   = cap_pt_q;
                        state_d    = S_RELEASE;
                    end else begin
                        auth_fail_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_REJECT;
                    end
                end
            end
            S_RELEASE: begin
                if (pt_ready) begin
                    pt_valid_d = 1'b0;
                    pt_out_d   = '0;
                    done_d     = 1'b1;
                    cap_pt_d   = '0;
                    cap_tag_d  = '0;
                    state_d    = S_IDLE;
                end
            end
            S_REJECT: begin
                cap_pt_d  = '0;
                cap_tag_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the tag and plaintext holding registers are cleared too, so an aborted
            // transaction leaves no secret material behind.
            state_q     <= S_IDLE;
            tag_q       <= '0;
            cap_tag_q   <= '0;
            cap_pt_q    <= '0;
            diff_q      <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            dec_ready_q <= 1'b0;
            dec_start_q <= 1'b0;
            pt_out_q    <= '0;
            pt_valid_q  <= 1'b0;
            auth_fail_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            tag_q       <= tag_d;
            cap_tag_q   <= cap_tag_d;
            cap_pt_q    <= cap_pt_d;
            diff_q      <= diff_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dec_ready_q <= dec_ready_d;
            dec_start_q <= dec_start_d;
            pt_out_q    <= pt_out_d;
            pt_valid_q  <= pt_valid_d;
            auth_fail_q <= auth_fail_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dec_start = dec_start_q;
    assign pt_out    = pt_out_q;
    assign pt_valid  = pt_valid_q;
    assign auth_fail = auth_fail_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ascon_auth_release.sv
// Directed bench for ascon_auth_release: pass, tag mismatch, backpressure, stale ready,
// timeout, ignored starts and mid-transaction reset, with a passive output monitor.
module tb_ascon_auth_release;

    localparam logic [127:0] T  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [39:0]  PA = 40'hA5A5A5A5A5;
    localparam logic [39:0]  PB = 40'h1234567890;
    localparam logic [39:0]  PC = 40'h00C0FFEE11;
    localparam logic [39:0]  PD = 40'h5A5A0F0F33;
    localparam logic [39:0]  PE = 40'hDEADBEEF77;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] tag_in;
    logic         dec_start;
    logic         dec_ready;
    logic [127:0] dec_tag;
    logic [39:0]  dec_pt;
    logic [39:0]  pt_out;
    logic         pt_valid;
    logic         pt_ready;
    logic         auth_fail;
    logic         timeout;
    logic         busy;
    logic         done;

    ascon_auth_release #(.text_l(40), .CHUNK(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .tag_in(tag_in),
        .dec_start(dec_start), .dec_ready(dec_ready), .dec_tag(dec_tag), .dec_pt(dec_pt),
        .pt_out(pt_out), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .auth_fail(auth_fail), .timeout(timeout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled on the falling edge.
    int          n_launch = 0, n_valid = 0, n_done = 0, n_leak = 0;
    int          t_launch = 0, t_fail = 0;
    logic [39:0] last_pt = '0;
    logic        af_prev = 1'b0;
    always @(negedge clk) begin
        if (dec_start) begin n_launch++; t_launch = cyc; end
        if (done) n_done++;
        if (pt_valid) begin n_valid++; last_pt = pt_out; end
        else if (pt_out != '0) n_leak++;
        if (auth_fail && !af_prev) t_fail = cyc;
        af_prev = auth_fail;
    end

    int n_checks = 0, n_pass = 0;
    int b_launch, b_valid, b_done, b_leak;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_launch = n_launch; b_valid = n_valid; b_done = n_done; b_leak = n_leak;
    endtask

    function automatic logic [127:0] outs();
        return {82'b0, dec_start, pt_valid, auth_fail, timeout, busy, done, pt_out};
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        check(tag, 128'(seen), 128'd1);
    endtask

    // Launch, raise dec_ready k cycles after dec_start, wait for done; returns edge-to-done.
    task automatic run_txn(input string tag, input logic [127:0] ttag, input logic [127:0] ctag,
                           input logic [39:0] pt, input int k, output int edge_to_done);
        int t_e;
        snap();
        tag_in = ttag; dec_tag = ctag; dec_pt = pt; dec_ready = 1'b0;
        do_start();
        repeat (k) tick();
        dec_ready = 1'b1;
        t_e = cyc;
        wait_done(tag, 40);
        edge_to_done = cyc - t_e;
        tick();
        dec_ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d_pass, d127, d0, stable;
        bit seen;

        rst = 1'b0; start = 1'b0; tag_in = '0; dec_ready = 1'b0;
        dec_tag = '0; dec_pt = '0; pt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), '0);
        rst = 1'b1;
        tick();

        // Matching tags, core ready 14 cycles after launch.
        pt_ready = 1'b1;
        run_txn("pass_done", T, T, PA, 14, d_pass);
        check("pass_launches", 128'(n_launch - b_launch), 128'd1);
        check("pass_valid_cycles", 128'(n_valid - b_valid), 128'd1);
        check("pass_pt", 128'(last_pt), 128'(PA));
        check("pass_done_pulses", 128'(n_done - b_done), 128'd1);
        check("pass_auth_fail", 128'(auth_fail), 128'd0);
        check("pass_no_leak", 128'(n_leak - b_leak), 128'd0);
        check("pass_idle", 128'(busy), 128'd0);

        // Single-bit mismatches at the top and bottom tag bits.
        run_txn("bit127_done", T, T ^ (128'd1 << 127), PA, 14, d127);
        check("bit127_flags", 128'({auth_fail, timeout}), 128'b10);
        check("bit127_no_valid", 128'(n_valid - b_valid), 128'd0);
        check("bit127_no_leak", 128'(n_leak - b_leak), 128'd0);
        run_txn("bit0_done", T, T ^ 128'd1, PA, 14, d0);
        check("bit0_flags", 128'({auth_fail, timeout}), 128'b10);
        check("bit0_no_valid", 128'(n_valid - b_valid), 128'd0);
        check("const_time", 128'(d0), 128'(d127));

        // Edge on the final wait cycle beats the timeout.
        run_txn("edge_wins_done", T, T, PD, 15, d0);
        check("edge_wins_flags", 128'({auth_fail, timeout}), 128'b00);
        check("edge_wins_valid", 128'(n_valid - b_valid), 128'd1);

        // Backpressure: pt_ready low for 5 cycles of RELEASE.
        snap();
        pt_ready = 1'b0; tag_in = T; dec_tag = T; dec_pt = PB;
        do_start();
        repeat (6) tick();
        dec_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pt_valid) begin seen = 1'b1; break; end
            tick();
        end
        check("bp_valid_seen", 128'(seen), 128'd1);
        stable = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) pt_ready = 1'b1;
            if (pt_valid && pt_out == PB && !done) stable++;
            tick();
        end
        check("bp_stable_cycles", 128'(stable), 128'd6);
        check("bp_done_after_accept", 128'({done, pt_valid, pt_out}), {86'b0, 1'b1, 1'b0, 40'h0});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_on_done_ignored", 128'({busy, dec_start}), 128'd0);
        dec_ready = 1'b0;
        tick();

        // Timeout with dec_ready stuck low.
        snap();
        do_start();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (auth_fail) begin seen = 1'b1; break; end
            tick();
        end
        check("to_seen", 128'(seen), 128'd1);
        repeat (3) tick();
        check("to_latency", 128'(t_fail - t_launch), 128'd16);
        check("to_flags_held", 128'({auth_fail, timeout, busy}), 128'b110);
        check("to_no_valid", 128'(n_valid - b_valid), 128'd0);
        check("to_done_pulses", 128'(n_done - b_done), 128'd1);

        // Stale ready level, then a real edge 13 cycles after launch.
        snap();
        dec_ready = 1'b1; dec_tag = ~T; dec_pt = PE; tag_in = T;
        repeat (2) tick();
        do_start();
        check("fail_cleared_on_start", 128'({auth_fail, timeout}), 128'd0);
        repeat (3) tick();
        dec_ready = 1'b0;
        repeat (10) tick();
        dec_tag = T; dec_pt = PC; dec_ready = 1'b1;
        wait_done("stale_done", 40);
        tick();
        dec_ready = 1'b0;
        tick();
        check("stale_auth_fail", 128'(auth_fail), 128'd0);
        check("stale_pt", 128'(last_pt), 128'(PC));
        check("stale_valid_cycles", 128'(n_valid - b_valid), 128'd1);

        // Start pulses during WAIT and CMP, tag_in changed after acceptance.
        snap();
        tag_in = T; dec_tag = T; dec_pt = PD;
        do_start();
        tag_in = ~T;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        dec_ready = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy_in_cmp", 128'(busy), 128'd1);
        wait_done("ign_done", 40);
        tick();
        dec_ready = 1'b0;
        tick();
        check("ign_launches", 128'(n_launch - b_launch), 128'd1);
        check("ign_pt", 128'(last_pt), 128'(PD));
        check("ign_auth_fail", 128'(auth_fail), 128'd0);
        check("ign_stays_idle", 128'(busy), 128'd0);

        // Reset asserted in CMP of a matching transaction.
        snap();
        tag_in = T; dec_tag = T; dec_pt = PE; pt_ready = 1'b1;
        do_start();
        repeat (4) tick();
        dec_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", outs(), '0);
        tick();
        rst = 1'b1;
        repeat (20) tick();
        check("mid_reset_no_valid", 128'(n_valid - b_valid), 128'd0);
        check("mid_reset_no_done", 128'(n_done - b_done), 128'd0);
        check("mid_reset_idle", outs(), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
